instruction_encoder: RTL and testbench
======================================

// Module: instruction_encoder
// PURPOSE
// - Inverse of the decode-side immediate generation: packs opcode, register indices, funct fields and a
//   32-bit immediate into a 32-bit RV32I instruction word.
// - Serves the debug program-buffer writer and self-test instruction injection.
// - 2-stage valid/ready pipeline. Flags immediates that are not representable in the chosen format.
// PARAMETERS
// - ERR_CNT_W  16  width of the saturating error counter
// PORTS
// - clk        in   1          clock
// - rst        in   1          synchronous active-high reset
// - in_valid   in   1          request valid
// - in_ready   out  1          request accepted when in_valid && in_ready
// - in_opcode  in   7          opcode (common_library.vh *_OPCODE values)
// - in_rd      in   5          destination register index
// - in_rs1     in   5          source register 1 index
// - in_rs2     in   5          source register 2 index
// - in_funct3  in   3          funct3 field
// - in_funct7  in   7          funct7 field (R-type and I-type shifts)
// - in_imm     in   32         immediate value, as the decoder would reproduce it
// - in_csr     in   12         CSR address (SYSTEM, funct3!=000)
// - out_valid  out  1          encoded word valid
// - out_ready  in   1          downstream accepts the word
// - out_instr  out  32         encoded instruction
// - out_err    out  1          immediate not representable, or opcode unknown
// - err_cnt    out  ERR_CNT_W  count of errored words handed off; saturates at all-ones
// BEHAVIOUR
// - Interface: one clock, clk; reset rst is synchronous and active-high.
// - Reset: s1_valid=0, out_valid=0, out_instr=0, out_err=0, err_cnt=0. Any in-flight words are dropped.
// - Pipeline control:
//   - S1 registers the inputs and computes err.
//   - S2 (output regs) packs the word.
//   - s2_adv = !out_valid || out_ready; s1_adv = s2_adv.
//   - in_ready = !s1_valid || s2_adv (combinational, no input-to-output path other than ready).
// - Timing: latency is 2 cycles from accept to out_valid; throughput is 1 word/cycle when out_ready=1.
// - Output stability: out_instr and out_err are held stable while out_valid && !out_ready.
// - Ordering: order is preserved; no word is dropped or duplicated.
// - Field placement: opcode is always [6:0]. Other fields per format:
//   - rd [11:7]: R, I, LOAD, JALR, JAL, LUI, AUIPC, FENCE, SYSTEM.
//   - rs1 [19:15]: R, I, LOAD, S, B, JALR, FENCE, SYSTEM (funct3[2]=0).
//   - rs2 [24:20]: R, S, B.
//   - funct3 [14:12]: all formats except JAL, LUI, AUIPC.
//   - funct7 [31:25]: R only, plus I-type shifts.
// - Immediate packing and range checks:
//   - I/LOAD/JALR: [31:20]=imm[11:0]; err unless imm[31:11] all equal.
//   - I shifts (funct3 001/101): [31:25]=funct7, [24:20]=imm[4:0]; err unless imm[31:5]==0.
//   - S: [31:25]=imm[11:5], [11:7]=imm[4:0]; err unless imm[31:11] all equal.
//   - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; err if imm[0]=1 or imm[31:12] not all equal.
//   - JAL: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; err if imm[0]=1 or imm[31:20] not all equal.
//   - LUI/AUIPC: [31:12]=imm[31:12]; err unless imm[11:0]==0.
//   - FENCE: [31:20]=imm[11:0]; err unless imm[31:12]==0.
//   - SYSTEM funct3==000: [31:20]=imm[11:0]; err unless imm[31:12]==0.
//   - SYSTEM funct3!=000: [31:20]=in_csr. If funct3[2]=1: [19:15]=imm[4:0], err unless imm[31:5]==0; otherwise imm is ignored.
//   - R: imm is ignored, never err.
//   - Unknown opcode: out_instr=32'h0000_0013 (NOP), out_err=1.
// - On a range error the truncated encoding is still emitted, with out_err=1.
// - err_cnt increments on the cycle out_valid && out_ready && out_err; it holds at all-ones once saturated.
// STRUCTURE
// - Shared package (common_library.vh): the existing *_OPCODE values; add FMT_R/I/S/B/U/J localparams
//   and SHIFT_FUNCT3 constants.
// - Sub-module imm_packer: combinational (opcode, funct3, imm, csr) -> {imm_bits[31:0], imm_err}.
//   Top level owns the pipeline registers, handshake and counter.
// TESTING
// - Encoding checks (out_ready held 1, out_valid 2 cycles after accept, out_err=0 unless stated):
//   - ADDI x1,x0 imm=0xFFFFFFFF -> 0xFFF00093. SLLI x1,x1 imm=3 -> 0x00309093. SLLI imm=32 -> out_err=1.
//   - BEQ rs1=1 rs2=2 imm=8 -> 0x00208463. imm=7 -> out_err=1.
//   - LUI x5 imm=0x12345000 -> 0x123452B7. imm=0x12345001 -> out_err=1, err_cnt 0->1 on handoff.
//   - JAL x1 imm=0x800 -> 0x001000EF. imm=0x00100000 -> out_err=1.
// - Backpressure: 3 back-to-back requests, out_ready=0 for 5 cycles -> 2 accepted, then in_ready=0;
//   out_instr stable; after release all 3 words emerge in order.
// - Reset with both stages full and err_cnt=5 -> next cycle out_valid=0, err_cnt=0, in_ready=1;
//   no stale word appears.
// - Saturation: ERR_CNT_W=2, 5 errored handoffs -> err_cnt=3 and holds.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared opcode/funct constants, format classification and range helpers for the RV32I instruction encoder.
package instruction_encoder_pkg;

   localparam logic [6:0] LUI_OPCODE      = 7'b0110111;
   localparam logic [6:0] AUIPC_OPCODE    = 7'b0010111;
   localparam logic [6:0] JAL_OPCODE      = 7'b1101111;
   localparam logic [6:0] JALR_OPCODE     = 7'b1100111;
   localparam logic [6:0] BRANCH_OPCODE   = 7'b1100011;
   localparam logic [6:0] LOAD_OPCODE     = 7'b0000011;
   localparam logic [6:0] STORE_OPCODE    = 7'b0100011;
   localparam logic [6:0] OP_IMM_OPCODE   = 7'b0010011;
   localparam logic [6:0] OP_OPCODE       = 7'b0110011;
   localparam logic [6:0] MISC_MEM_OPCODE = 7'b0001111;
   localparam logic [6:0] SYSTEM_OPCODE   = 7'b1110011;

   localparam logic [2:0] SLLI_FUNCT3      = 3'b001;
   localparam logic [2:0] SRLI_SRAI_FUNCT3 = 3'b101;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_e;

   function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
      case (opcode)
         OP_OPCODE:                                           return FMT_R;
         OP_IMM_OPCODE, LOAD_OPCODE, JALR_OPCODE,
         MISC_MEM_OPCODE, SYSTEM_OPCODE:                      return FMT_I;
         STORE_OPCODE:                                        return FMT_S;
         BRANCH_OPCODE:                                       return FMT_B;
         LUI_OPCODE, AUIPC_OPCODE:                            return FMT_U;
         JAL_OPCODE:                                          return FMT_J;
         default:                                             return FMT_NONE;
      endcase
   endfunction

   function automatic logic is_shift(input logic [2:0] funct3);
      return (funct3 == SLLI_FUNCT3) || (funct3 == SRLI_SRAI_FUNCT3);
   endfunction

   // True when v[31:msb] are all equal, i.e. v is a sign extension of v[msb:0].
   function automatic logic fits_signed(input logic [31:0] v, input int msb);
      logic signed [31:0] s;
      s = $signed(v) >>> msb;
      return (s == '0) || (&s);
   endfunction

endpackage

// File: rtl/instruction_encoder_imm_packer.sv
// Places the immediate (or CSR / zimm) bits of an RV32I word and flags values the format cannot represent.
module instruction_encoder_imm_packer
   import instruction_encoder_pkg::*;
(
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] imm_i,
   input  logic [11:0] csr_i,
   output logic [31:0] imm_bits_o,
   output logic        imm_err_o
);

   always_comb begin
      imm_bits_o = '0;
      imm_err_o  = 1'b0;
      case (opcode_i)
         OP_IMM_OPCODE, LOAD_OPCODE, JALR_OPCODE: begin
            if (opcode_i == OP_IMM_OPCODE && is_shift(funct3_i)) begin
               imm_bits_o[24:20] = imm_i[4:0];
               imm_err_o         = |imm_i[31:5];
            end else begin
               imm_bits_o[31:20] = imm_i[11:0];
               imm_err_o         = !fits_signed(imm_i, 11);
            end
         end
         STORE_OPCODE: begin
            imm_bits_o[31:25] = imm_i[11:5];
            imm_bits_o[11:7]  = imm_i[4:0];
            imm_err_o         = !fits_signed(imm_i, 11);
         end
         BRANCH_OPCODE: begin
            imm_bits_o[31]    = imm_i[12];
            imm_bits_o[7]     = imm_i[11];
            imm_bits_o[30:25] = imm_i[10:5];
            imm_bits_o[11:8]  = imm_i[4:1];
            imm_err_o         = imm_i[0] || !fits_signed(imm_i, 12);
         end
         JAL_OPCODE: begin
            imm_bits_o[31]    = imm_i[20];
            imm_bits_o[30:21] = imm_i[10:1];
            imm_bits_o[20]    = imm_i[11];
            imm_bits_o[19:12] = imm_i[19:12];
            imm_err_o         = imm_i[0] || !fits_signed(imm_i, 20);
         end
         LUI_OPCODE, AUIPC_OPCODE: begin
            imm_bits_o[31:12] = imm_i[31:12];
            imm_err_o         = |imm_i[11:0];
         end
         MISC_MEM_OPCODE: begin
            imm_bits_o[31:20] = imm_i[11:0];
            imm_err_o         = |imm_i[31:12];
         end
         SYSTEM_OPCODE: begin
            // CSR forms carry the CSR address; the immediate variants put zimm in the rs1 slot.
            if (funct3_i == 3'b000) begin
               imm_bits_o[31:20] = imm_i[11:0];
               imm_err_o         = |imm_i[31:12];
            end else begin
               imm_bits_o[31:20] = csr_i;
               if (funct3_i[2]) begin
                  imm_bits_o[19:15] = imm_i[4:0];
                  imm_err_o         = |imm_i[31:5];
               end
            end
         end
         OP_OPCODE: begin
            imm_err_o = 1'b0;
         end
         default: begin
            imm_err_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage valid/ready RV32I instruction encoder: S1 registers the request, S2 holds the packed word.
module instruction_encoder
   import instruction_encoder_pkg::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [31:0]          in_imm,
   input  logic [11:0]          in_csr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic                 s1_valid_q;
   logic [6:0]           s1_opcode_q;
   logic [4:0]           s1_rd_q, s1_rs1_q, s1_rs2_q;
   logic [2:0]           s1_funct3_q;
   logic [6:0]           s1_funct7_q;
   logic [31:0]          s1_imm_q;
   logic [11:0]          s1_csr_q;
   logic                 out_valid_q, out_err_q;
   logic [31:0]          out_instr_q;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [31:0]          imm_bits, instr_d;
   logic                 imm_err, err_d, s2_adv;
   fmt_e                 fmt;

   assign s2_adv   = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_adv;

   instruction_encoder_imm_packer u_imm_packer (
      .opcode_i   (s1_opcode_q),
      .funct3_i   (s1_funct3_q),
      .imm_i      (s1_imm_q),
      .csr_i      (s1_csr_q),
      .imm_bits_o (imm_bits),
      .imm_err_o  (imm_err)
   );

   always_comb begin
      fmt     = opcode_fmt(s1_opcode_q);
      instr_d = imm_bits | {25'b0, s1_opcode_q};
      err_d   = imm_err;
      if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J)
         instr_d[11:7] = s1_rd_q;
      // CSR immediate forms reuse the rs1 slot for zimm, already placed by the packer.
      if ((fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B) &&
          !(s1_opcode_q == SYSTEM_OPCODE && s1_funct3_q[2]))
         instr_d[19:15] = s1_rs1_q;
      if (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B)
         instr_d[24:20] = s1_rs2_q;
      if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B)
         instr_d[14:12] = s1_funct3_q;
      if (fmt == FMT_R || (s1_opcode_q == OP_IMM_OPCODE && is_shift(s1_funct3_q)))
         instr_d[31:25] = s1_funct7_q;
      if (fmt == FMT_NONE)
         instr_d = NOP_INSTR;
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (out_valid_q && out_ready && out_err_q && !(&err_cnt_q))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   // S1: request capture
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         s1_opcode_q <= in_opcode;
         s1_rd_q     <= in_rd;
         s1_rs1_q    <= in_rs1;
         s1_rs2_q    <= in_rs2;
         s1_funct3_q <= in_funct3;
         s1_funct7_q <= in_funct7;
         s1_imm_q    <= in_imm;
         s1_csr_q    <= in_csr;
      end
   end

   // S2: output registers, handshake control and error counter
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         if (in_ready)
            s1_valid_q <= in_valid;
         if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_instr_q <= instr_d;
               out_err_q   <= err_d;
            end
         end
         err_cnt_q <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_err   = out_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed encodings, backpressure, randomized scoreboard, saturation, reset.
module tb_instruction_encoder;

   typedef struct packed {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [11:0] csr;
   } req_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic        in_ready, out_valid, out_err;
   logic        in_ready2, out_valid2, out_err2;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [31:0] in_imm, out_instr, out_instr2;
   logic [11:0] in_csr;
   logic [15:0] err_cnt;
   logic [1:0]  err_cnt2;

   int checks   = 0;
   int failures = 0;

   logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                            7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

   always #5 clk = ~clk;

   instruction_encoder #(.ERR_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_csr(in_csr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_err(out_err), .err_cnt(err_cnt)
   );

   instruction_encoder #(.ERR_CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_csr(in_csr),
      .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
      .out_err(out_err2), .err_cnt(err_cnt2)
   );

   function automatic req_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm, input logic [11:0] csr);
      req_t r;
      r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
      r.f3 = f3; r.f7 = f7; r.imm = imm; r.csr = csr;
      return r;
   endfunction

   // Reference: assemble each format directly from its field layout and value ranges.
   function automatic void model(input req_t r, output logic [31:0] w, output logic e);
      logic [31:0] i;
      int          s;
      i = r.imm;
      s = int'($signed(r.imm));
      w = 32'h0;
      e = 1'b0;
      case (r.op)
         7'h33: w = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
         7'h13, 7'h03, 7'h67: begin
            if (r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5)) begin
               w = {r.f7, i[4:0], r.rs1, r.f3, r.rd, r.op};
               e = (r.imm > 32'd31);
            end else begin
               w = {i[11:0], r.rs1, r.f3, r.rd, r.op};
               e = (s < -2048) || (s > 2047);
            end
         end
         7'h23: begin
            w = {i[11:5], r.rs2, r.rs1, r.f3, i[4:0], r.op};
            e = (s < -2048) || (s > 2047);
         end
         7'h63: begin
            w = {i[12], i[10:5], r.rs2, r.rs1, r.f3, i[4:1], i[11], r.op};
            e = (s < -4096) || (s > 4095) || i[0];
         end
         7'h6F: begin
            w = {i[20], i[10:1], i[11], i[19:12], r.rd, r.op};
            e = (s < -1048576) || (s > 1048575) || i[0];
         end
         7'h37, 7'h17: begin
            w = {i[31:12], r.rd, r.op};
            e = (r.imm % 32'd4096) != 32'd0;
         end
         7'h0F: begin
            w = {i[11:0], r.rs1, r.f3, r.rd, r.op};
            e = (r.imm > 32'd4095);
         end
         7'h73: begin
            if (r.f3 == 3'd0) begin
               w = {i[11:0], r.rs1, r.f3, r.rd, r.op};
               e = (r.imm > 32'd4095);
            end else if (r.f3 >= 3'd4) begin
               w = {r.csr, i[4:0], r.f3, r.rd, r.op};
               e = (r.imm > 32'd31);
            end else begin
               w = {r.csr, r.rs1, r.f3, r.rd, r.op};
            end
         end
         default: begin
            w = 32'h0000_0013;
            e = 1'b1;
         end
      endcase
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.op  = ops[$urandom_range(0, 11)];
      r.rd  = 5'($urandom());
      r.rs1 = 5'($urandom());
      r.rs2 = 5'($urandom());
      r.f3  = 3'($urandom());
      r.f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom());
      r.csr = 12'($urandom());
      case ($urandom_range(0, 4))
         0: r.imm = $urandom_range(0, 4095) - 32'd2048;
         1: r.imm = $urandom_range(0, 63);
         2: r.imm = $urandom();
         3: r.imm = $urandom() & 32'hFFFF_F000;
         default: r.imm = ($urandom_range(0, 8191) - 32'd4096) & 32'hFFFF_FFFE;
      endcase
      return r;
   endfunction

   task automatic apply(input req_t r);
      in_opcode = r.op;  in_rd  = r.rd;  in_rs1 = r.rs1; in_rs2 = r.rs2;
      in_funct3 = r.f3;  in_funct7 = r.f7; in_imm = r.imm; in_csr = r.csr;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
      checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_encoding;
      req_t        vr [12];
      logic [31:0] vw [12];
      logic        ve [12];
      int          nerr = 0;
      vr[0]  = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 12'h0); vw[0]  = 32'hFFF00093; ve[0]  = 1'b0;
      vr[1]  = mk(7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'd3, 12'h0);        vw[1]  = 32'h00309093; ve[1]  = 1'b0;
      vr[2]  = mk(7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'd32, 12'h0);       vw[2]  = 32'h00009093; ve[2]  = 1'b1;
      vr[3]  = mk(7'h63, 5'd5, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8, 12'h0);        vw[3]  = 32'h00208463; ve[3]  = 1'b0;
      vr[4]  = mk(7'h63, 5'd5, 5'd1, 5'd2, 3'd0, 7'h00, 32'd7, 12'h0);        vw[4]  = 32'h00208363; ve[4]  = 1'b1;
      vr[5]  = mk(7'h37, 5'd5, 5'd3, 5'd0, 3'd7, 7'h00, 32'h1234_5000, 12'h0); vw[5]  = 32'h123452B7; ve[5]  = 1'b0;
      vr[6]  = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 12'h0); vw[6]  = 32'h123452B7; ve[6]  = 1'b1;
      vr[7]  = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 12'h0); vw[7]  = 32'h001000EF; ve[7]  = 1'b0;
      vr[8]  = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 12'h0); vw[8]  = 32'h800000EF; ve[8]  = 1'b1;
      vr[9]  = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8, 12'h0);        vw[9]  = 32'h0020A423; ve[9]  = 1'b0;
      vr[10] = mk(7'h73, 5'd3, 5'd9, 5'd0, 3'd5, 7'h00, 32'd5, 12'h305);      vw[10] = 32'h3052D1F3; ve[10] = 1'b0;
      vr[11] = mk(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'd0, 12'h0);        vw[11] = 32'h00000013; ve[11] = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         apply(vr[k]); in_valid = 1'b1; out_ready = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL enc%0d_in_ready got=%b exp=1", k, in_ready); end
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL enc%0d_latency got=%b exp=0", k, out_valid); end
         @(negedge clk); #1;
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL enc%0d_valid got=%b exp=1", k, out_valid); end
         checks++; if (out_instr !== vw[k]) begin failures++; $display("FAIL enc%0d_instr got=%h exp=%h", k, out_instr, vw[k]); end
         checks++; if (out_err !== ve[k]) begin failures++; $display("FAIL enc%0d_err got=%b exp=%b", k, out_err, ve[k]); end
         checks++; if (err_cnt !== 16'(nerr)) begin failures++; $display("FAIL enc%0d_cnt_before got=%0d exp=%0d", k, err_cnt, nerr); end
         if (ve[k]) nerr++;
         @(negedge clk); #1;
         checks++; if (err_cnt !== 16'(nerr)) begin failures++; $display("FAIL enc%0d_cnt_after got=%0d exp=%0d", k, err_cnt, nerr); end
      end
   endtask

   task automatic test_back_to_back;
      req_t        r  [3];
      logic [31:0] ew [3];
      logic        ee [3];
      int          acc = 0;
      int          got = 0;
      r[0] = mk(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'h00, 32'd5, 12'h0);
      r[1] = mk(7'h23, 5'd0, 5'd4, 5'd6, 3'd2, 7'h00, 32'hFFFF_FFF0, 12'h0);
      r[2] = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 12'h0);
      for (int k = 0; k < 3; k++) model(r[k], ew[k], ee[k]);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         in_valid  = (acc < 3);
         if (acc < 3) apply(r[acc]);
         #1;
         if (c >= 2) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_in_ready c=%0d got=%b exp=0", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_instr !== ew[0]) begin
               failures++; $display("FAIL b2b_stall_hold c=%0d got=%b/%h exp=1/%h", c, out_valid, out_instr, ew[0]); end
         end
         if (in_valid && in_ready) acc++;
      end
      checks++; if (acc != 2) begin failures++; $display("FAIL b2b_accepted got=%0d exp=2", acc); end
      for (int c = 0; c < 12 && got < 3; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = (acc < 3);
         if (acc < 3) apply(r[acc]);
         #1;
         if (in_valid && in_ready) acc++;
         if (out_valid) begin
            checks++; if (out_instr !== ew[got] || out_err !== ee[got]) begin
               failures++; $display("FAIL b2b_order%0d got=%h/%b exp=%h/%b", got, out_instr, out_err, ew[got], ee[got]); end
            got++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (got != 3 || acc != 3) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=3/3", got, acc); end
   endtask

   task automatic test_random;
      logic [32:0] q [$];
      req_t        cur;
      logic        have = 1'b0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_w = 32'h0;
      logic        prev_e = 1'b0;
      logic [31:0] w;
      logic        e;
      logic [32:0] exp_v;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!have && $urandom_range(0, 3) != 0) begin cur = rand_req(); have = 1'b1; end
         in_valid = have;
         if (have) apply(cur);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (prev_stall) begin
            checks++; if (out_valid !== 1'b1 || out_instr !== prev_w || out_err !== prev_e) begin
               failures++; $display("FAIL rnd_hold c=%0d got=%b/%h/%b exp=1/%h/%b", c, out_valid, out_instr, out_err, prev_w, prev_e); end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL rnd_extra c=%0d got=%h exp=none", c, out_instr);
            end else begin
               exp_v = q.pop_front();
               if ({out_err, out_instr} !== exp_v) begin
                  failures++; $display("FAIL rnd_word c=%0d got=%b/%h exp=%b/%h", c, out_err, out_instr, exp_v[32], exp_v[31:0]); end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_w     = out_instr;
         prev_e     = out_err;
         if (in_valid && in_ready) begin
            model(cur, w, e);
            q.push_back({e, w});
            have = 1'b0;
         end
      end
      for (int c = 0; c < 10 && q.size() > 0; c++) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         #1;
         if (out_valid) begin
            exp_v = q.pop_front();
            checks++; if ({out_err, out_instr} !== exp_v) begin
               failures++; $display("FAIL rnd_drain got=%b/%h exp=%b/%h", out_err, out_instr, exp_v[32], exp_v[31:0]); end
         end
      end
      checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_lost got=%0d exp=0", q.size()); end
   endtask

   task automatic test_saturation;
      int n_acc = 0;
      int n_out = 0;
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 30 && n_out < 5; c++) begin
         @(negedge clk);
         apply(mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 12'h0));
         in_valid = (n_acc < 5);
         out_ready = 1'b1;
         #1;
         checks++; if (err_cnt2 !== 2'((n_out > 3) ? 3 : n_out)) begin
            failures++; $display("FAIL sat_cnt2 n=%0d got=%0d exp=%0d", n_out, err_cnt2, (n_out > 3) ? 3 : n_out); end
         checks++; if (err_cnt !== 16'(n_out)) begin failures++; $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", n_out, err_cnt, n_out); end
         if (in_valid && in_ready) n_acc++;
         if (out_valid && out_err) n_out++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (n_out != 5) begin failures++; $display("FAIL sat_handoffs got=%0d exp=5", n_out); end
      checks++; if (err_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_final2 got=%0d exp=3", err_cnt2); end
      checks++; if (err_cnt !== 16'd5) begin failures++; $display("FAIL sat_final got=%0d exp=5", err_cnt); end
   endtask

   task automatic test_reset_midflight;
      int acc = 0;
      for (int c = 0; c < 6 && acc < 2; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         apply(mk(7'h13, 5'd7, 5'd7, 5'd0, 3'd0, 7'h00, 32'd100, 12'h0));
         in_valid = 1'b1;
         #1;
         if (in_valid && in_ready) acc++;
      end
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || err_cnt !== 16'd5) begin
         failures++; $display("FAIL rstmid_full got=%b/%b/%0d exp=1/0/5", out_valid, in_ready, err_cnt); end
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      checks++; if (err_cnt !== 16'd0 || err_cnt2 !== 2'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", err_cnt, err_cnt2); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
      rst = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); #1;
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale c=%0d got=%b exp=0", c, out_valid); end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      apply(mk(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0, 12'h0));
      test_reset;
      test_encoding;
      test_back_to_back;
      test_random;
      test_saturation;
      test_reset_midflight;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
